ioctl_rom_streamer: RTL and testbench
=====================================

// Module: ioctl_rom_streamer
// PURPOSE
//  Initiator side of the ioctl ROM-download bus consumed by the core top level.
//  Takes a start command (index, length) plus a valid/ready byte stream and
//  drives ioctl_download/ioctl_wr/ioctl_addr/ioctl_dout/ioctl_index, honouring
//  ioctl_wait. Used by simulation benches and the on-chip loader to load ROMs.
// PARAMETERS
//  ADDR_W        25  width of ioctl_addr and len_i
//  SETUP_CYCLES   4  cycles ioctl_download is high before first ioctl_wr (>=1)
//  GAP_CYCLES     2  idle cycles after each ioctl_wr pulse before the next (>=1)
//  TAIL_CYCLES    4  cycles ioctl_download stays high after last ioctl_wr (>=1)
// PORTS
//  clk_sys         in   1       system clock; all logic on rising edge
//  reset_n         in   1       synchronous reset, active low
//  start_i         in   1       1-cycle start pulse; sampled only in IDLE
//  index_i         in   8       ROM index, captured on accepted start
//  len_i           in   ADDR_W  byte count, captured on accepted start
//  abort_i         in   1       finish early after any in-flight write
//  src_valid_i     in   1       byte available
//  src_data_i      in   8       byte value
//  src_ready_o     out  1       byte consumed when src_valid_i & src_ready_o
//  ioctl_download  out  1       download window
//  ioctl_wr        out  1       1-cycle write strobe
//  ioctl_addr      out  ADDR_W  byte address, 0-based
//  ioctl_dout      out  8       write data
//  ioctl_index     out  8       ROM index
//  ioctl_wait      in   1       receiver back-pressure
//  busy_o          out  1       high in every state except IDLE
//  done_o          out  1       1-cycle pulse on return to IDLE
// BEHAVIOUR
//  Reset (reset_n=0 at edge): every output 0, state IDLE, counters 0; takes
//   effect on the same edge even mid-transfer (download drops, no tail).
//  States: IDLE -> SETUP -> FETCH -> WRITE -> GAP -> FETCH ... -> TAIL -> IDLE.
//  IDLE: start_i=1 captures index/len, ioctl_index<=index_i, ioctl_addr<=0,
//   ioctl_download<=1, -> SETUP. start_i in any other state is ignored.
//  SETUP: count SETUP_CYCLES; then -> FETCH, or -> TAIL if len==0 or abort seen.
//  FETCH: src_ready_o=1 only when ioctl_wait=0 (combinational). On handshake
//   ioctl_dout<=src_data_i, -> WRITE. If ioctl_wait=1, no byte is taken.
//  WRITE: ioctl_wr=1 exactly one cycle; ioctl_addr/dout stable this cycle.
//   Write counted; -> GAP.
//  GAP: ioctl_wr=0 for GAP_CYCLES; on exit ioctl_addr<=addr+1 (wraps modulo
//   2^ADDR_W); -> TAIL if count==len or abort latched, else FETCH.
//  ioctl_wait may rise any cycle; it only blocks the next FETCH handshake, never
//   an already-issued WRITE. ioctl_dout/addr hold between writes.
//  abort_i: latched in any non-IDLE state; in FETCH -> TAIL immediately (no
//   byte taken); in WRITE/GAP current write completes first. Cleared in IDLE.
//  TAIL: ioctl_download=1 for TAIL_CYCLES, then 0; -> IDLE with done_o=1.
//  Minimum write spacing: 1+GAP_CYCLES+1 cycles (WRITE, GAP, FETCH).
//  ioctl_index holds its value after the transfer until next start.
// TESTING
//  1. len=3, bytes A5,5A,FF, wait=0 -> 3 wr pulses addr 0,1,2 data A5,5A,FF,
//     download high SETUP+3*(2+GAP)+TAIL cycles, one done_o pulse.
//  2. len=4, ioctl_wait=1 for 10 cycles after first wr -> no wr and src_ready_o=0
//     while high; all 4 bytes delivered in order, addresses contiguous.
//  3. len=0, index=8'h02 -> download high SETUP+TAIL cycles, zero wr, done_o.
//  4. abort_i during 3rd WRITE of len=10 -> 3rd write completes, total 3 wr,
//     TAIL then IDLE; second start_i during transfer ignored.
//  5. reset_n low mid-GAP -> next edge all outputs 0, IDLE; new start works.
//  6. src_valid_i gaps (random) with len=256 -> addr 0..255, data matches
//     source sequence, no duplicate or dropped bytes.

Source files
------------

// File: rtl/ioctl_rom_streamer.sv
// Initiator for the ioctl ROM-download bus: turns a start command plus a
// valid/ready byte stream into ioctl_download/wr/addr/dout strobes.
module ioctl_rom_streamer #(
    parameter int ADDR_W       = 25,
    parameter int SETUP_CYCLES = 4,
    parameter int GAP_CYCLES   = 2,
    parameter int TAIL_CYCLES  = 4
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              start_i,
    input  logic [7:0]        index_i,
    input  logic [ADDR_W-1:0] len_i,
    input  logic              abort_i,
    input  logic              src_valid_i,
    input  logic [7:0]        src_data_i,
    output logic              src_ready_o,
    output logic              ioctl_download,
    output logic              ioctl_wr,
    output logic [ADDR_W-1:0] ioctl_addr,
    output logic [7:0]        ioctl_dout,
    output logic [7:0]        ioctl_index,
    input  logic              ioctl_wait,
    output logic              busy_o,
    output logic              done_o
);

    localparam int CW = 16;
    localparam logic [CW-1:0] SETUP_LAST = CW'(SETUP_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST   = CW'(GAP_CYCLES - 1);
    localparam logic [CW-1:0] TAIL_LAST  = CW'(TAIL_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        FETCH,
        WRITE,
        GAP,
        TAIL
    } state_t;

    state_t            state_q;
    logic [CW-1:0]     cnt_q;
    logic [CW-1:0]     cnt_d;
    logic [ADDR_W-1:0] len_q;
    logic [ADDR_W-1:0] wrCount_q;
    logic [ADDR_W-1:0] addr_d;
    logic              abort_q;
    logic              abortSeen;
    logic              handshake;

    // An abort asserted this cycle acts immediately, without waiting for the latch.
    assign abortSeen   = abort_q | abort_i;
    assign src_ready_o = (state_q == FETCH) & ~ioctl_wait & ~abortSeen;
    assign handshake   = src_ready_o & src_valid_i;
    assign busy_o      = (state_q != IDLE);
    assign cnt_d       = cnt_q + 1'b1;
    assign addr_d      = ioctl_addr + 1'b1;

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            len_q          <= '0;
            wrCount_q      <= '0;
            abort_q        <= 1'b0;
            ioctl_download <= 1'b0;
            ioctl_wr       <= 1'b0;
            ioctl_addr     <= '0;
            ioctl_dout     <= '0;
            ioctl_index    <= '0;
            done_o         <= 1'b0;
        end else begin
            done_o <= 1'b0;
            if (state_q != IDLE && abort_i) begin
                abort_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    abort_q <= 1'b0;
                    if (start_i) begin
                        len_q          <= len_i;
                        ioctl_index    <= index_i;
                        ioctl_addr     <= '0;
                        ioctl_download <= 1'b1;
                        wrCount_q      <= '0;
                        cnt_q          <= '0;
                        state_q        <= SETUP;
                    end
                end
                SETUP: begin
                    if (cnt_q == SETUP_LAST) begin
                        cnt_q   <= '0;
                        state_q <= (len_q == '0 || abortSeen) ? TAIL : FETCH;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                FETCH: begin
                    if (abortSeen) begin
                        cnt_q   <= '0;
                        state_q <= TAIL;
                    end else if (handshake) begin
                        ioctl_dout <= src_data_i;
                        ioctl_wr   <= 1'b1;
                        state_q    <= WRITE;
                    end
                end
                WRITE: begin
                    ioctl_wr  <= 1'b0;
                    wrCount_q <= wrCount_q + 1'b1;
                    cnt_q     <= '0;
                    state_q   <= GAP;
                end
                GAP: begin
                    // Address advances only once the gap ends, so it holds across the pause.
                    if (cnt_q == GAP_LAST) begin
                        cnt_q      <= '0;
                        ioctl_addr <= addr_d;
                        state_q    <= (wrCount_q == len_q || abortSeen) ? TAIL : FETCH;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                TAIL: begin
                    if (cnt_q == TAIL_LAST) begin
                        cnt_q          <= '0;
                        ioctl_download <= 1'b0;
                        done_o         <= 1'b1;
                        state_q        <= IDLE;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ioctl_rom_streamer.sv
// Directed bench for ioctl_rom_streamer: a byte source with optional gaps,
// a negedge bus monitor and one task per scenario with inline checks.
module tb_ioctl_rom_streamer;

    logic        clk_sys;
    logic        reset_n;
    logic        start_i;
    logic [7:0]  index_i;
    logic [24:0] len_i;
    logic        abort_i;
    logic        src_valid_i;
    logic [7:0]  src_data_i;
    logic        src_ready_o;
    logic        ioctl_download;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic [7:0]  ioctl_index;
    logic        ioctl_wait;
    logic        busy_o;
    logic        done_o;

    int total = 0;
    int bad   = 0;

    bit [24:0]  wrAddr[$];
    bit [7:0]   wrData[$];
    int         dlCycles;
    int         doneCnt;
    int         readyWhileWait;
    bit         hsNow;

    logic [7:0] srcMem[0:255];
    int         srcLen;
    int         srcPtr;
    bit         srcGaps;

    ioctl_rom_streamer dut (
        .clk_sys       (clk_sys),
        .reset_n       (reset_n),
        .start_i       (start_i),
        .index_i       (index_i),
        .len_i         (len_i),
        .abort_i       (abort_i),
        .src_valid_i   (src_valid_i),
        .src_data_i    (src_data_i),
        .src_ready_o   (src_ready_o),
        .ioctl_download(ioctl_download),
        .ioctl_wr      (ioctl_wr),
        .ioctl_addr    (ioctl_addr),
        .ioctl_dout    (ioctl_dout),
        .ioctl_index   (ioctl_index),
        .ioctl_wait    (ioctl_wait),
        .busy_o        (busy_o),
        .done_o        (done_o)
    );

    initial begin
        clk_sys = 1'b0;
        forever #5 clk_sys = ~clk_sys;
    end

    // Bus monitor samples mid-cycle, well away from the rising edge.
    always @(negedge clk_sys) begin
        if (ioctl_wr) begin
            wrAddr.push_back(ioctl_addr);
            wrData.push_back(ioctl_dout);
        end
        if (ioctl_download) dlCycles++;
        if (done_o) doneCnt++;
        if (src_ready_o && ioctl_wait) readyWhileWait++;
        hsNow = src_valid_i && src_ready_o;
    end

    always @(posedge clk_sys) begin
        #2;
        if (hsNow) srcPtr++;
        hsNow = 1'b0;
        if (srcPtr < srcLen && (!srcGaps || $urandom_range(0, 2) != 0)) begin
            src_valid_i = 1'b1;
            src_data_i  = srcMem[srcPtr];
        end else begin
            src_valid_i = 1'b0;
            src_data_i  = 8'h00;
        end
    end

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic clearMon();
        wrAddr.delete();
        wrData.delete();
        dlCycles       = 0;
        doneCnt        = 0;
        readyWhileWait = 0;
    endtask

    task automatic loadSrc(input int n, input bit gaps, input int seed);
        for (int i = 0; i < 256; i++) srcMem[i] = 8'(i * 7 + seed);
        srcLen  = n;
        srcPtr  = 0;
        srcGaps = gaps;
        hsNow   = 1'b0;
    endtask

    task automatic applyStimulus(input logic [7:0] idx, input logic [24:0] len);
        index_i = idx;
        len_i   = len;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    task automatic waitDone(input string name, input int budget);
        int n = 0;
        while (doneCnt == 0 && n < budget) begin
            tick();
            n++;
        end
        total++;
        if (doneCnt == 0) begin
            bad++;
            $display("[TB] FAIL %s_timeout: no done_o within %0d cycles", name, budget);
        end
        repeat (3) tick();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) tick();
        total++;
        if ({ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, ioctl_index,
             busy_o, done_o, src_ready_o} !== '0) begin
            bad++;
            $display("[TB] FAIL reset_outputs: got dl=%b wr=%b addr=%0h dout=%0h idx=%0h busy=%b done=%b rdy=%b want all 0",
                     ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, ioctl_index, busy_o, done_o, src_ready_o);
        end
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        logic [7:0] exp[3];
        exp[0] = 8'hA5; exp[1] = 8'h5A; exp[2] = 8'hFF;
        loadSrc(3, 1'b0, 0);
        srcMem[0] = 8'hA5; srcMem[1] = 8'h5A; srcMem[2] = 8'hFF;
        clearMon();
        applyStimulus(8'h11, 25'd3);
        waitDone("basic", 100);
        total++;
        if (wrAddr.size() != 3) begin
            bad++;
            $display("[TB] FAIL basic_wrcount: got %0d want 3", wrAddr.size());
        end
        for (int i = 0; i < 3 && i < wrAddr.size(); i++) begin
            total++;
            if (wrAddr[i] !== 25'(i) || wrData[i] !== exp[i]) begin
                bad++;
                $display("[TB] FAIL basic_wr%0d: got addr=%0h data=%0h want addr=%0h data=%0h",
                         i, wrAddr[i], wrData[i], i, exp[i]);
            end
        end
        total++;
        if (dlCycles != 20) begin
            bad++;
            $display("[TB] FAIL basic_dlcycles: got %0d want 20", dlCycles);
        end
        total++;
        if (doneCnt != 1) begin
            bad++;
            $display("[TB] FAIL basic_done: got %0d pulses want 1", doneCnt);
        end
        total++;
        if (ioctl_index !== 8'h11 || ioctl_dout !== 8'hFF || ioctl_addr !== 25'd3) begin
            bad++;
            $display("[TB] FAIL basic_hold: got idx=%0h dout=%0h addr=%0h want 11 ff 3",
                     ioctl_index, ioctl_dout, ioctl_addr);
        end
        total++;
        if (busy_o !== 1'b0 || ioctl_download !== 1'b0) begin
            bad++;
            $display("[TB] FAIL basic_idle: got busy=%b dl=%b want 0 0", busy_o, ioctl_download);
        end
    endtask

    task automatic test_wait();
        int n = 0;
        int n0;
        loadSrc(4, 1'b0, 0);
        srcMem[0] = 8'h11; srcMem[1] = 8'h22; srcMem[2] = 8'h33; srcMem[3] = 8'h44;
        clearMon();
        applyStimulus(8'h21, 25'd4);
        while (wrAddr.size() < 1 && n < 50) begin
            tick();
            n++;
        end
        ioctl_wait = 1'b1;
        n0 = wrAddr.size();
        repeat (10) tick();
        total++;
        if (wrAddr.size() != n0 || n0 != 1) begin
            bad++;
            $display("[TB] FAIL wait_nowr: got %0d writes during wait (start %0d) want 0 (start 1)",
                     wrAddr.size() - n0, n0);
        end
        ioctl_wait = 1'b0;
        waitDone("wait", 200);
        total++;
        if (readyWhileWait != 0) begin
            bad++;
            $display("[TB] FAIL wait_ready: got %0d ready cycles during wait want 0", readyWhileWait);
        end
        total++;
        if (wrAddr.size() != 4) begin
            bad++;
            $display("[TB] FAIL wait_wrcount: got %0d want 4", wrAddr.size());
        end
        for (int i = 0; i < 4 && i < wrAddr.size(); i++) begin
            total++;
            if (wrAddr[i] !== 25'(i) || wrData[i] !== 8'(8'h11 * (i + 1))) begin
                bad++;
                $display("[TB] FAIL wait_wr%0d: got addr=%0h data=%0h want addr=%0h data=%0h",
                         i, wrAddr[i], wrData[i], i, 8'(8'h11 * (i + 1)));
            end
        end
    endtask

    task automatic test_zero_len();
        loadSrc(0, 1'b0, 0);
        clearMon();
        applyStimulus(8'h02, 25'd0);
        waitDone("zero", 50);
        total++;
        if (dlCycles != 8 || wrAddr.size() != 0) begin
            bad++;
            $display("[TB] FAIL zero_window: got dl=%0d wr=%0d want dl=8 wr=0", dlCycles, wrAddr.size());
        end
        total++;
        if (doneCnt != 1 || ioctl_index !== 8'h02 || ioctl_addr !== 25'd0) begin
            bad++;
            $display("[TB] FAIL zero_state: got done=%0d idx=%0h addr=%0h want 1 02 0",
                     doneCnt, ioctl_index, ioctl_addr);
        end
    endtask

    task automatic test_abort();
        int n = 0;
        loadSrc(10, 1'b0, 1);
        clearMon();
        applyStimulus(8'h44, 25'd10);
        tick();
        applyStimulus(8'h77, 25'd5);
        while (n < 100) begin
            @(negedge clk_sys);
            #1;
            if (ioctl_wr && wrAddr.size() == 3) break;
            n++;
        end
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        waitDone("abort", 100);
        repeat (10) tick();
        total++;
        if (wrAddr.size() != 3 || srcPtr != 3) begin
            bad++;
            $display("[TB] FAIL abort_count: got wr=%0d consumed=%0d want 3 3", wrAddr.size(), srcPtr);
        end
        total++;
        if (doneCnt != 1 || busy_o !== 1'b0 || ioctl_download !== 1'b0) begin
            bad++;
            $display("[TB] FAIL abort_end: got done=%0d busy=%b dl=%b want 1 0 0", doneCnt, busy_o, ioctl_download);
        end
        total++;
        if (ioctl_index !== 8'h44 || wrData.size() < 3 || wrData[2] !== 8'(2 * 7 + 1)) begin
            bad++;
            $display("[TB] FAIL abort_ignore: got idx=%0h want 44 with 3rd byte %0h", ioctl_index, 8'(2 * 7 + 1));
        end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        loadSrc(5, 1'b0, 3);
        clearMon();
        applyStimulus(8'h55, 25'd5);
        while (wrAddr.size() < 1 && n < 50) begin
            tick();
            n++;
        end
        reset_n = 1'b0;
        tick();
        total++;
        if ({ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, ioctl_index,
             busy_o, done_o, src_ready_o} !== '0) begin
            bad++;
            $display("[TB] FAIL midreset_outputs: got dl=%b wr=%b addr=%0h dout=%0h idx=%0h busy=%b done=%b want all 0",
                     ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, ioctl_index, busy_o, done_o);
        end
        reset_n = 1'b1;
        tick();
        loadSrc(2, 1'b0, 9);
        clearMon();
        applyStimulus(8'h05, 25'd2);
        waitDone("midreset", 100);
        total++;
        if (wrAddr.size() != 2 || doneCnt != 1 || ioctl_index !== 8'h05) begin
            bad++;
            $display("[TB] FAIL midreset_restart: got wr=%0d done=%0d idx=%0h want 2 1 05",
                     wrAddr.size(), doneCnt, ioctl_index);
        end
        total++;
        if (wrData.size() < 2 || wrData[0] !== 8'd9 || wrData[1] !== 8'd16 || wrAddr[1] !== 25'd1) begin
            bad++;
            $display("[TB] FAIL midreset_data: got %0d entries want data 09,10 at addr 0,1", wrData.size());
        end
    endtask

    task automatic test_long_gaps();
        int errs = 0;
        loadSrc(256, 1'b1, 3);
        clearMon();
        applyStimulus(8'h06, 25'd256);
        waitDone("long", 6000);
        srcGaps = 1'b0;
        total++;
        if (wrAddr.size() != 256) begin
            bad++;
            $display("[TB] FAIL long_wrcount: got %0d want 256", wrAddr.size());
        end
        for (int i = 0; i < 256 && i < wrAddr.size(); i++) begin
            if (wrAddr[i] !== 25'(i) || wrData[i] !== srcMem[i]) errs++;
        end
        total++;
        if (errs != 0) begin
            bad++;
            $display("[TB] FAIL long_sequence: got %0d mismatching writes want 0", errs);
        end
        total++;
        if (doneCnt != 1 || ioctl_addr !== 25'd256) begin
            bad++;
            $display("[TB] FAIL long_end: got done=%0d addr=%0h want 1 100", doneCnt, ioctl_addr);
        end
    endtask

    initial begin
        reset_n     = 1'b0;
        start_i     = 1'b0;
        index_i     = '0;
        len_i       = '0;
        abort_i     = 1'b0;
        ioctl_wait  = 1'b0;
        src_valid_i = 1'b0;
        src_data_i  = '0;
        srcLen      = 0;
        srcPtr      = 0;
        srcGaps     = 1'b0;
        clearMon();
        $display("[TB] starting ioctl_rom_streamer bench");
        test_reset();
        test_basic();
        test_wait();
        test_zero_len();
        test_abort();
        test_reset_mid();
        test_long_gaps();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
